// File: rtl/frame_sorter_pkg.sv
// Shared types and helpers for the frame sorter: FSM state encoding and
// the pad word that fills unused slots of a partial frame.
package frame_sorter_pkg;

  // Frame controller states: collect words, sort once, stream results out.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Widest word the pad helper can describe.
  localparam int MAX_DW = 64;

  // Pad word that always sorts to the tail of the frame: all ones for an
  // ascending sort, all zeros for a descending one. Only the low 'width'
  // bits are meaningful; the caller slices them off.
  function automatic logic [MAX_DW-1:0] pad_value(input int width, input int order);
    logic [MAX_DW-1:0] v;
    v = '0;
    if (order == 0) begin
      for (int b = 0; b < MAX_DW; b++) begin
        if (b < width) v[b] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/frame_sorter_bn.sv
// Combinational bitonic sorting network over 2**LP words of dw bits.
// Word i of the flat buses lives at bits [i*dw +: dw]; index 0 of the
// output is the first word in the selected order.
module BN #(
  parameter int LP  = 3,
  parameter int dw  = 8,
  parameter int dir = 0
) (
  input  logic [(2**LP)*dw-1:0] data_i,
  output logic [(2**LP)*dw-1:0] data_o
);

  localparam int N = 2**LP;

  logic [dw-1:0] w_net [N];
  logic [dw-1:0] w_tmp;
  logic          w_up;

  // Classic bitonic merge passes; the final k=N pass orders the whole
  // frame in the requested direction.
  always_comb begin
    w_tmp = '0;
    w_up  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_net[i] = data_i[i*dw +: dw];
    end
    for (int k = 2; k <= N; k = k * 2) begin
      for (int j = k / 2; j > 0; j = j / 2) begin
        for (int i = 0; i < N; i++) begin
          if ((i ^ j) > i) begin
            w_up = (((i & k) == 0) == (dir == 0));
            if (w_up ? (w_net[i] > w_net[i ^ j]) : (w_net[i] < w_net[i ^ j])) begin
              w_tmp        = w_net[i];
              w_net[i]     = w_net[i ^ j];
              w_net[i ^ j] = w_tmp;
            end
          end
        end
      end
    end
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      data_o[i*dw +: dw] = w_net[i];
    end
  end

endmodule

// File: rtl/frame_sorter.sv
// Frame sorter: buffers up to 2**LP words (a frame may be closed early
// with last_i), sorts them in one cycle through a bitonic network, then
// streams exactly the received words out over a req/ack port.
module frame_sorter
  import frame_sorter_pkg::*;
#(
  parameter int LP  = 3,
  parameter int dw  = 8,
  parameter int dir = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] data_i,
  input  logic          last_i,
  input  logic          req_i,
  output logic          ack_i,
  output logic [dw-1:0] data_o,
  output logic          last_o,
  output logic          req_o,
  input  logic          ack_o
);

  localparam int                N        = 2**LP;
  localparam logic [LP:0]       CNT_LAST = (LP+1)'(N - 1);
  localparam logic [LP:0]       CNT_ONE  = (LP+1)'(1);
  localparam logic [MAX_DW-1:0] PAD_FULL = pad_value(dw, dir);
  localparam logic [dw-1:0]     PAD      = PAD_FULL[dw-1:0];

  state_t        r_state;
  logic [LP:0]   r_cnt;
  logic [LP:0]   r_idx;
  logic [LP:0]   r_nvalid;
  logic          r_ack_i;
  logic          r_req_o;
  logic          r_last_o;
  logic [dw-1:0] r_data_o;

  logic [dw-1:0] r_buf    [N];
  logic [dw-1:0] r_sorted [N];

  logic [N*dw-1:0] w_buf_flat;
  logic [N*dw-1:0] w_sorted_flat;
  logic [dw-1:0]   w_sorted [N];
  logic            w_in_xfer;
  logic            w_close;
  logic            w_out_xfer;
  logic [LP:0]     w_idx_next;

  // ack_i is only ever high in FILL, so an input transfer implies FILL.
  assign w_in_xfer  = req_i & r_ack_i;
  // A frame closes on its N-th word or on any word flagged last.
  assign w_close    = w_in_xfer & (last_i | (r_cnt == CNT_LAST));
  assign w_out_xfer = r_req_o & ack_o;
  assign w_idx_next = r_idx + CNT_ONE;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flat
      assign w_buf_flat[gi*dw +: dw] = r_buf[gi];
      assign w_sorted[gi]            = w_sorted_flat[gi*dw +: dw];
    end
  endgenerate

  BN #(LP, dw, dir) u_bn (
    .data_i (w_buf_flat),
    .data_o (w_sorted_flat)
  );

  // Frame buffer: store the accepted word; on frame close, pad every later slot.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      for (int i = 0; i < N; i++) begin
        if (w_close && ((LP+1)'(i) > r_cnt)) r_buf[i] <= PAD;
      end
      r_buf[r_cnt[LP-1:0]] <= data_i;
    end
  end

  // Snapshot the network output during the single SORT cycle.
  always_ff @(posedge clk) begin
    if (r_state == SORT) begin
      for (int i = 0; i < N; i++) begin
        r_sorted[i] <= w_sorted[i];
      end
    end
  end

  // Frame controller with registered handshake and output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FILL;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_nvalid <= '0;
      r_ack_i  <= 1'b0;
      r_req_o  <= 1'b0;
      r_last_o <= 1'b0;
      r_data_o <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_ack_i <= 1'b1;
          if (w_in_xfer) begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_close) begin
              r_state <= SORT;
              r_ack_i <= 1'b0;
            end
          end
        end
        SORT: begin
          // r_cnt already counts the closing word, so it is the frame length.
          r_nvalid <= r_cnt;
          r_idx    <= '0;
          r_data_o <= w_sorted[0];
          r_last_o <= (r_cnt == CNT_ONE);
          r_req_o  <= 1'b1;
          r_state  <= DRAIN;
        end
        DRAIN: begin
          if (w_out_xfer) begin
            if (r_last_o) begin
              r_state  <= FILL;
              r_cnt    <= '0;
              r_idx    <= '0;
              r_req_o  <= 1'b0;
              r_last_o <= 1'b0;
              r_data_o <= '0;
              r_ack_i  <= 1'b1;
            end else begin
              r_idx    <= w_idx_next;
              r_data_o <= r_sorted[w_idx_next[LP-1:0]];
              r_last_o <= (w_idx_next == (r_nvalid - CNT_ONE));
            end
          end
        end
        default: begin
          r_state <= FILL;
          r_ack_i <= 1'b0;
          r_req_o <= 1'b0;
        end
      endcase
    end
  end

  assign ack_i  = r_ack_i;
  assign req_o  = r_req_o;
  assign last_o = r_last_o;
  assign data_o = r_data_o;

endmodule

// File: tb/tb_frame_sorter.sv
// Directed bench for frame_sorter: one ascending and one descending
// instance share the same stimulus and run in lock-step.
module tb_frame_sorter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       last_i = 1'b0;
  logic       req_i = 1'b0;
  logic       ack_o = 1'b0;

  logic       ack_i0, last_o0, req_o0;
  logic       ack_i1, last_o1, req_o1;
  logic [7:0] data_o0, data_o1;

  int checks = 0;
  int failures = 0;

  logic [7:0] got_d  [16];
  logic [7:0] got1_d [16];
  logic       got_l  [16];
  int got_n;
  int to_cnt;
  int ack_seen;

  always #5 clk = ~clk;

  frame_sorter #(.LP(3), .dw(8), .dir(0)) dut0 (
    .clk(clk), .rst(rst), .data_i(data_i), .last_i(last_i), .req_i(req_i),
    .ack_i(ack_i0), .data_o(data_o0), .last_o(last_o0), .req_o(req_o0), .ack_o(ack_o)
  );

  frame_sorter #(.LP(3), .dw(8), .dir(1)) dut1 (
    .clk(clk), .rst(rst), .data_i(data_i), .last_i(last_i), .req_i(req_i),
    .ack_i(ack_i1), .data_o(data_o1), .last_o(last_o1), .req_o(req_o1), .ack_o(ack_o)
  );

  // Drive n words (called on a falling edge); returns on the falling edge after the final transfer.
  task automatic push_words(input logic [7:0] v [8], input int n, input bit mark_last, input bit keep_req);
    for (int w = 0; w < n; w++) begin
      int g;
      g = 0;
      data_i = v[w];
      last_i = mark_last && (w == n - 1);
      req_i  = 1'b1;
      while (ack_i0 !== 1'b1 && g < 40) begin
        @(negedge clk);
        g++;
      end
      if (g >= 40) to_cnt++;
      $display("in  word %0d data=%0d last=%0b", w, v[w], last_i);
      @(negedge clk);
    end
    last_i = 1'b0;
    if (!keep_req) req_i = 1'b0;
  endtask

  // Accept output words with ack_o high until a last_o transfer (bounded).
  task automatic collect();
    int g;
    g = 0;
    got_n = 0;
    ack_seen = 0;
    ack_o = 1'b1;
    while (g < 40 && got_n < 16) begin
      if (ack_i0 === 1'b1) ack_seen++;
      if (req_o0 === 1'b1) begin
        got_d[got_n]  = data_o0;
        got1_d[got_n] = data_o1;
        got_l[got_n]  = last_o0;
        $display("out word %0d data=%0d data_desc=%0d last=%0b", got_n, data_o0, data_o1, last_o0);
        got_n++;
        if (last_o0 === 1'b1) begin
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
      g++;
    end
    if (g >= 40) to_cnt++;
    ack_o = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (req_o0 !== 1'b0) begin failures++; $display("FAIL reset_req_o got=%0b want=0", req_o0); end
    checks++; if (last_o0 !== 1'b0) begin failures++; $display("FAIL reset_last_o got=%0b want=0", last_o0); end
    checks++; if (data_o0 !== 8'd0) begin failures++; $display("FAIL reset_data_o got=%0d want=0", data_o0); end
    checks++; if (ack_i0 !== 1'b0 || ack_i1 !== 1'b0) begin failures++; $display("FAIL reset_ack_i got=%0b/%0b want=0", ack_i0, ack_i1); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack_i0 !== 1'b1) begin failures++; $display("FAIL reset_release_ack_i got=%0b want=1", ack_i0); end
  endtask

  task automatic test_full_frame();
    logic [7:0] v [8];
    logic [7:0] e [8];
    logic [7:0] ed [8];
    v  = '{7, 3, 9, 1, 0, 255, 4, 4};
    e  = '{0, 1, 3, 4, 4, 7, 9, 255};
    ed = '{255, 9, 7, 4, 4, 3, 1, 0};
    to_cnt = 0;
    push_words(v, 8, 1'b0, 1'b0);
    checks++; if (req_o0 !== 1'b0 || ack_i0 !== 1'b0) begin failures++; $display("FAIL full_sort_cycle req_o=%0b ack_i=%0b want 0/0", req_o0, ack_i0); end
    @(negedge clk);
    checks++; if (req_o0 !== 1'b1) begin failures++; $display("FAIL full_latency_req_o got=%0b want=1", req_o0); end
    collect();
    checks++; if (got_n !== 8) begin failures++; $display("FAIL full_count got=%0d want=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_d[i] !== e[i] || got1_d[i] !== ed[i] || got_l[i] !== (i == 7)) begin
        failures++;
        $display("FAIL full_word%0d got=%0d/%0d last=%0b want=%0d/%0d last=%0b", i, got_d[i], got1_d[i], got_l[i], e[i], ed[i], (i == 7));
      end
    end
    checks++; if (ack_i0 !== 1'b1 || req_o0 !== 1'b0) begin failures++; $display("FAIL full_return_fill ack_i=%0b req_o=%0b want 1/0", ack_i0, req_o0); end
    checks++; if (to_cnt !== 0) begin failures++; $display("FAIL full_timeout got=%0d want=0", to_cnt); end
  endtask

  task automatic test_partial();
    logic [7:0] v [8];
    v = '{5, 2, 0, 0, 0, 0, 0, 0};
    to_cnt = 0;
    push_words(v, 2, 1'b1, 1'b0);
    collect();
    checks++; if (got_n !== 2) begin failures++; $display("FAIL partial_count got=%0d want=2", got_n); end
    checks++; if (got_d[0] !== 8'd2 || got_d[1] !== 8'd5) begin failures++; $display("FAIL partial_asc got=%0d,%0d want=2,5", got_d[0], got_d[1]); end
    checks++; if (got1_d[0] !== 8'd5 || got1_d[1] !== 8'd2) begin failures++; $display("FAIL partial_desc got=%0d,%0d want=5,2", got1_d[0], got1_d[1]); end
    checks++; if (got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin failures++; $display("FAIL partial_last got=%0b,%0b want=0,1", got_l[0], got_l[1]); end
    checks++; if (ack_i0 !== 1'b1 || req_o0 !== 1'b0 || to_cnt !== 0) begin failures++; $display("FAIL partial_return_fill ack_i=%0b req_o=%0b to=%0d want 1/0/0", ack_i0, req_o0, to_cnt); end
  endtask

  task automatic test_pad_collision();
    logic [7:0] v [8];
    v = '{255, 255, 10, 0, 0, 0, 0, 0};
    to_cnt = 0;
    push_words(v, 3, 1'b1, 1'b0);
    collect();
    checks++; if (got_n !== 3) begin failures++; $display("FAIL pad_count got=%0d want=3", got_n); end
    checks++; if (got_d[0] !== 8'd10 || got_d[1] !== 8'd255 || got_d[2] !== 8'd255) begin failures++; $display("FAIL pad_asc got=%0d,%0d,%0d want=10,255,255", got_d[0], got_d[1], got_d[2]); end
    checks++; if (got1_d[0] !== 8'd255 || got1_d[1] !== 8'd255 || got1_d[2] !== 8'd10) begin failures++; $display("FAIL pad_desc got=%0d,%0d,%0d want=255,255,10", got1_d[0], got1_d[1], got1_d[2]); end
    checks++; if (got_l[2] !== 1'b1 || got_l[1] !== 1'b0 || to_cnt !== 0) begin failures++; $display("FAIL pad_last got=%0b,%0b to=%0d want=0,1,0", got_l[1], got_l[2], to_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] v [8];
    logic [7:0] e [8];
    v = '{20, 10, 30, 40, 5, 15, 25, 35};
    e = '{5, 10, 15, 20, 25, 30, 35, 40};
    to_cnt = 0;
    push_words(v, 8, 1'b0, 1'b0);
    @(negedge clk);
    ack_o = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_o0 !== 1'b1 || data_o0 !== e[c]) begin failures++; $display("FAIL bp_pre%0d got=%0d req=%0b want=%0d req=1", c, data_o0, req_o0, e[c]); end
      $display("out word %0d data=%0d last=%0b", c, data_o0, last_o0);
      @(negedge clk);
    end
    ack_o = 1'b0;
    for (int s = 0; s < 5; s++) begin
      checks++; if (req_o0 !== 1'b1 || data_o0 !== 8'd20 || last_o0 !== 1'b0) begin failures++; $display("FAIL bp_stall%0d got=%0d req=%0b last=%0b want=20 req=1 last=0", s, data_o0, req_o0, last_o0); end
      @(negedge clk);
    end
    collect();
    checks++; if (got_n !== 5) begin failures++; $display("FAIL bp_count got=%0d want=5", got_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_d[i] !== e[i + 3] || got_l[i] !== (i == 4)) begin
        failures++;
        $display("FAIL bp_word%0d got=%0d last=%0b want=%0d last=%0b", i + 3, got_d[i], got_l[i], e[i + 3], (i == 4));
      end
    end
    checks++; if (to_cnt !== 0) begin failures++; $display("FAIL bp_timeout got=%0d want=0", to_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] v [8];
    logic [7:0] w [8];
    v = '{60, 50, 40, 30, 20, 10, 70, 80};
    w = '{9, 8, 7, 0, 0, 0, 0, 0};
    to_cnt = 0;
    push_words(v, 8, 1'b0, 1'b0);
    @(negedge clk);
    ack_o = 1'b1;
    repeat (3) @(negedge clk);
    ack_o = 1'b0;
    checks++; if (data_o0 !== 8'd40 || req_o0 !== 1'b1) begin failures++; $display("FAIL rst_pre_word got=%0d req=%0b want=40 req=1", data_o0, req_o0); end
    rst = 1'b1;
    #1;
    checks++; if (req_o0 !== 1'b0 || req_o1 !== 1'b0) begin failures++; $display("FAIL rst_mid_req_o got=%0b/%0b want=0", req_o0, req_o1); end
    checks++; if (ack_i0 !== 1'b0 || data_o0 !== 8'd0 || last_o0 !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs ack_i=%0b data=%0d last=%0b want 0/0/0", ack_i0, data_o0, last_o0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack_i0 !== 1'b1 || req_o0 !== 1'b0) begin failures++; $display("FAIL rst_recover ack_i=%0b req_o=%0b want 1/0", ack_i0, req_o0); end
    push_words(w, 3, 1'b1, 1'b0);
    collect();
    checks++; if (got_n !== 3) begin failures++; $display("FAIL rst_next_count got=%0d want=3", got_n); end
    checks++; if (got_d[0] !== 8'd7 || got_d[1] !== 8'd8 || got_d[2] !== 8'd9 || got_l[2] !== 1'b1) begin failures++; $display("FAIL rst_next_words got=%0d,%0d,%0d last=%0b want=7,8,9 last=1", got_d[0], got_d[1], got_d[2], got_l[2]); end
    checks++; if (to_cnt !== 0) begin failures++; $display("FAIL rst_timeout got=%0d want=0", to_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [8];
    logic [7:0] ea [8];
    logic [7:0] b [8];
    logic [7:0] eb [8];
    a  = '{12, 200, 3, 77, 45, 45, 0, 99};
    ea = '{0, 3, 12, 45, 45, 77, 99, 200};
    b  = '{250, 1, 128, 64, 32, 16, 8, 2};
    eb = '{1, 2, 8, 16, 32, 64, 128, 250};
    to_cnt = 0;
    push_words(a, 8, 1'b0, 1'b1);
    data_i = b[0];
    checks++; if (ack_i0 !== 1'b0) begin failures++; $display("FAIL b2b_sort_ack_i got=%0b want=0", ack_i0); end
    @(negedge clk);
    collect();
    checks++; if (ack_seen !== 0) begin failures++; $display("FAIL b2b_drain_ack_i high_cycles=%0d want=0", ack_seen); end
    checks++; if (ack_i0 !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble ack_i=%0b want=1", ack_i0); end
    checks++; if (got_n !== 8) begin failures++; $display("FAIL b2b_a_count got=%0d want=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_d[i] !== ea[i]) begin failures++; $display("FAIL b2b_a_word%0d got=%0d want=%0d", i, got_d[i], ea[i]); end
    end
    push_words(b, 8, 1'b0, 1'b0);
    collect();
    checks++; if (got_n !== 8) begin failures++; $display("FAIL b2b_b_count got=%0d want=8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_d[i] !== eb[i] || got_l[i] !== (i == 7)) begin failures++; $display("FAIL b2b_b_word%0d got=%0d last=%0b want=%0d last=%0b", i, got_d[i], got_l[i], eb[i], (i == 7)); end
    end
    checks++; if (to_cnt !== 0) begin failures++; $display("FAIL b2b_timeout got=%0d want=0", to_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial();
    test_pad_collision();
    test_backpressure();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
